// File: rtl/mram_pkg.sv
// Shared types, widths and helpers for the MRAM access controller.
package mram_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef logic [1:0] state_t;
    localparam state_t StIdle  = 2'd0;
    localparam state_t StSetup = 2'd1;
    localparam state_t StPulse = 2'd2;
    localparam state_t StHold  = 2'd3;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mram_req_t;

    // Counter only ever holds T_x-1, so log2 of the largest phase is enough.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < BE_W; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

endpackage

// File: rtl/mram_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last time wins.
module mram_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic last_q;

    always_comb begin
        gnt_id_o = 1'b0;
        gnt_o    = 2'b00;
        if (en_i) begin
            gnt_id_o = (&valid_i) ? ~last_q : valid_i[1];
            if (|valid_i) gnt_o = gnt_id_o ? 2'b10 : 2'b01;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (|gnt_o) begin
            last_q <= gnt_id_o;
        end
    end

endmodule

// File: rtl/mram_access_ctrl.sv
// Sequences timed async-SRAM-style accesses to the external MRAM for two requesters.
module mram_access_ctrl
    import mram_pkg::*;
#(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 4,
    parameter int unsigned T_HOLD  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic              req0_we_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    input  logic [BE_W-1:0]   req0_be_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic              req1_we_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    input  logic [BE_W-1:0]   req1_be_i,
    output logic              rsp_valid_o,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mram_addr_o,
    output logic [DATA_W-1:0] mram_dq_out_o,
    output logic              mram_dq_oe_o,
    input  logic [DATA_W-1:0] mram_dq_in_i,
    output logic              mram_e_n_o,
    output logic              mram_w_n_o,
    output logic              mram_g_n_o,
    output logic              mram_lb_n_o,
    output logic              mram_ub_n_o
);

    localparam int unsigned CntW = cnt_width(T_SETUP, T_PULSE, T_HOLD);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    mram_req_t       req_q, req_sel;
    logic            id_q;
    logic            rsp_valid_q, rsp_id_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [1:0]      gnt;
    logic            gnt_id;
    logic            last_pulse;
    logic            active;

    mram_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .en_i     ((state_q == StIdle) && !rst),
        .valid_i  ({req1_valid_i, req0_valid_i}),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign req0_ready_o = gnt[0];
    assign req1_ready_o = gnt[1];

    always_comb begin
        req_sel = gnt_id ? '{we: req1_we_i, addr: req1_addr_i, wdata: req1_wdata_i, be: req1_be_i}
                         : '{we: req0_we_i, addr: req0_addr_i, wdata: req0_wdata_i, be: req0_be_i};
    end

    assign last_pulse = (state_q == StPulse) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        case (state_q)
            StIdle: begin
                if (|gnt) begin
                    // Empty byte mask skips the strobe phases entirely.
                    if (req_sel.be == '0) begin
                        state_d = StHold;
                        cnt_d   = CntW'(T_HOLD - 1);
                    end else begin
                        state_d = StSetup;
                        cnt_d   = CntW'(T_SETUP - 1);
                    end
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StPulse;
                    cnt_d   = CntW'(T_PULSE - 1);
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    cnt_d   = CntW'(T_HOLD - 1);
                end
            end
            StHold: begin
                if (cnt_q == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_q       <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= 1'b0;
            if (|gnt) begin
                req_q <= req_sel;
                id_q  <= gnt_id;
                if (!req_sel.we && (req_sel.be == '0)) begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= gnt_id;
                    rsp_rdata_q <= '0;
                end
            end
            if (last_pulse && !req_q.we) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_rdata_q <= mram_dq_in_i & lane_mask(req_q.be);
            end
        end
    end

    assign active = (state_q != StIdle) && (req_q.be != '0);

    assign busy_o        = (state_q != StIdle);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_id_o      = rsp_id_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign mram_addr_o   = req_q.addr;
    assign mram_dq_out_o = req_q.wdata;
    assign mram_dq_oe_o  = active && req_q.we;
    assign mram_e_n_o    = !active;
    assign mram_w_n_o    = !(active && req_q.we && (state_q == StPulse));
    // Output enable only before HOLD, so the bus is released a phase before CE#.
    assign mram_g_n_o    = !(active && !req_q.we && ((state_q == StSetup) || (state_q == StPulse)));
    assign mram_lb_n_o   = !(active && req_q.be[0]);
    assign mram_ub_n_o   = !(active && req_q.be[1]);

endmodule
